// File: rtl/store_pkg.sv
// store_pkg: shared types and funct3 encodings for the store alignment path.
package store_pkg;
  typedef enum logic [1:0] {IDLE, WORD0, WORD1} state_e;
  typedef logic [3:0] be_t;
  localparam logic [2:0] F3_SB = 3'b000;
  localparam logic [2:0] F3_SH = 3'b001;
  localparam logic [2:0] F3_SW = 3'b010;
  function automatic be_t base_be(input logic [2:0] f3);
    return f3 == F3_SB ? 4'b0001 : f3 == F3_SH ? 4'b0011 : f3 == F3_SW ? 4'b1111 : 4'b0000;
  endfunction
endpackage

// File: rtl/store_lane_shift.sv
// store_lane_shift: maps store size/offset/data onto a two-word lane window.
module store_lane_shift
  import store_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  off,
  input  logic [31:0] data,
  output logic [7:0]  be8,
  output logic [63:0] data64,
  output logic        split,
  output logic        misaligned,
  output logic        illegal
);
  logic [31:0] masked;
  always_comb begin
    illegal    = funct3 != F3_SB && funct3 != F3_SH && funct3 != F3_SW;
    // Bytes outside the store size are zeroed so unused write lanes stay 0.
    masked     = funct3 == F3_SB ? {24'b0, data[7:0]} : funct3 == F3_SH ? {16'b0, data[15:0]} : data;
    be8        = {4'b0, base_be(funct3)} << off;
    data64     = {32'b0, masked} << {off, 3'b000};
    split      = |be8[7:4];
    misaligned = (funct3 == F3_SH && off[0]) || (funct3 == F3_SW && off != 2'b00);
  end
endmodule

// File: rtl/store_align_unit.sv
// store_align_unit: issues aligned byte-enabled memory writes for SB/SH/SW (MISALIGN_SPLIT_EN enables split stores).
module store_align_unit
  import store_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              st_valid,
  output logic              st_ready,
  input  logic [2:0]        st_funct3,
  input  logic [ADDR_W-1:0] st_addr,
  input  logic [31:0]       st_data,
  output logic              st_done,
  output logic              st_misaligned,
  output logic              st_illegal,
  output logic              mem_req,
  input  logic              mem_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic [3:0]        mem_be
);
`ifdef MISALIGN_SPLIT_EN
  localparam logic SPLIT_EN = 1'b1;
`else
  localparam logic SPLIT_EN = 1'b0;
`endif
  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d, hi_wdata_q, hi_wdata_d;
  be_t               be_q, be_d, hi_be_q, hi_be_d;
  logic              split_q, split_d, done_q, done_d, mis_q, mis_d, ill_q, ill_d;
  logic [7:0]        be8;
  logic [63:0]       data64;
  logic              split, misaligned, illegal;
  store_lane_shift u_shift (
    .funct3(st_funct3),
    .off(st_addr[1:0]),
    .data(st_data),
    .be8(be8),
    .data64(data64),
    .split(split),
    .misaligned(misaligned),
    .illegal(illegal)
  );
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    be_d       = be_q;
    hi_wdata_d = hi_wdata_q;
    hi_be_d    = hi_be_q;
    split_d    = split_q;
    done_d     = 1'b0;
    mis_d      = 1'b0;
    ill_d      = 1'b0;
    case (state_q)
      IDLE: if (st_valid) begin
        if (illegal) ill_d = 1'b1;
        else if (misaligned && !SPLIT_EN) mis_d = 1'b1;
        else begin
          state_d    = WORD0;
          addr_d     = {st_addr[ADDR_W-1:2], 2'b00};
          wdata_d    = data64[31:0];
          be_d       = be8[3:0];
          hi_wdata_d = data64[63:32];
          hi_be_d    = be8[7:4];
          split_d    = split && SPLIT_EN;
        end
      end
      WORD0: if (mem_ready) begin
        if (split_q) begin
          state_d = WORD1;
          addr_d  = addr_q + ADDR_W'(4);
          wdata_d = hi_wdata_q;
          be_d    = hi_be_q;
        end else begin
          state_d = IDLE;
          done_d  = 1'b1;
          addr_d  = '0;
          wdata_d = '0;
          be_d    = '0;
        end
      end
      WORD1: if (mem_ready) begin
        state_d = IDLE;
        done_d  = 1'b1;
        addr_d  = '0;
        wdata_d = '0;
        be_d    = '0;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      wdata_q    <= '0;
      be_q       <= '0;
      hi_wdata_q <= '0;
      hi_be_q    <= '0;
      split_q    <= 1'b0;
      done_q     <= 1'b0;
      mis_q      <= 1'b0;
      ill_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      be_q       <= be_d;
      hi_wdata_q <= hi_wdata_d;
      hi_be_q    <= hi_be_d;
      split_q    <= split_d;
      done_q     <= done_d;
      mis_q      <= mis_d;
      ill_q      <= ill_d;
    end
  end
  assign st_ready      = state_q == IDLE;
  assign mem_req       = state_q != IDLE;
  assign mem_addr      = addr_q;
  assign mem_wdata     = wdata_q;
  assign mem_be        = be_q;
  assign st_done       = done_q;
  assign st_misaligned = mis_q;
  assign st_illegal    = ill_q;
endmodule

// File: tb/tb_store_align_unit.sv
// tb_store_align_unit: scoreboard bench for store_align_unit; expected writes queued per store, checked by a monitor.
module tb_store_align_unit;
  logic        clk = 1'b0;
  logic        rst_n, st_valid, st_ready, st_done, st_misaligned, st_illegal;
  logic        mem_req, mem_ready;
  logic [2:0]  st_funct3;
  logic [31:0] st_addr, st_data, mem_addr, mem_wdata;
  logic [3:0]  mem_be;
  logic [67:0] exp_q[$];
  int          n_checks = 0;
  int          n_fail = 0;
  always #5 clk = ~clk;
  store_align_unit #(.ADDR_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .st_valid(st_valid), .st_ready(st_ready),
    .st_funct3(st_funct3), .st_addr(st_addr), .st_data(st_data),
    .st_done(st_done), .st_misaligned(st_misaligned), .st_illegal(st_illegal),
    .mem_req(mem_req), .mem_ready(mem_ready), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_be(mem_be)
  );
  // Every cycle with mem_req high must present the oldest expected write; pop on handshake.
  always @(negedge clk) begin
    if (mem_req) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL mem_write unexpected: addr=%h be=%b wdata=%h, none required", mem_addr, mem_be, mem_wdata);
      end else if ({mem_addr, mem_be, mem_wdata} !== exp_q[0]) begin
        n_fail++;
        $display("FAIL mem_write: addr=%h be=%b wdata=%h, required addr=%h be=%b wdata=%h",
                 mem_addr, mem_be, mem_wdata, exp_q[0][67:36], exp_q[0][35:32], exp_q[0][31:0]);
      end
      if (mem_ready && exp_q.size() != 0) void'(exp_q.pop_front());
    end
  end
  task automatic push(input logic [31:0] a, input logic [3:0] be, input logic [31:0] d);
    exp_q.push_back({a, be, d});
  endtask
  // kind: 0 none, 1 done, 2 misaligned, 3 illegal; lat counts cycles after acceptance.
  task automatic run_store(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d,
                           input int stall, input bit poke,
                           output int kind, output int lat, output bit req_seen, output bit rdy_at_end);
    kind = 0; lat = -1; req_seen = 0; rdy_at_end = 0;
    @(posedge clk); #1;
    st_valid = 1'b1; st_funct3 = f3; st_addr = a; st_data = d;
    @(posedge clk); #1;
    st_valid = 1'b0;
    for (int c = 0; c < 60 && kind == 0; c++) begin
      mem_ready = (c >= stall);
      if (poke && c < stall) begin
        st_valid = 1'b1; st_funct3 = 3'b011; st_addr = 32'h0000_0040;
      end else st_valid = 1'b0;
      @(negedge clk);
      if (mem_req) req_seen = 1;
      if (st_done) kind = 1; else if (st_misaligned) kind = 2; else if (st_illegal) kind = 3;
      if (kind != 0) begin lat = c; rdy_at_end = st_ready; end
      @(posedge clk); #1;
    end
    mem_ready = 1'b0; st_valid = 1'b0;
  endtask
  task automatic test_reset();
    n_checks++;
    if ({st_ready, mem_req, st_done, st_misaligned, st_illegal} !== 5'b10000) begin
      n_fail++;
      $display("FAIL reset_ctrl: ready/req/done/mis/ill=%b, required 10000",
               {st_ready, mem_req, st_done, st_misaligned, st_illegal});
    end
    n_checks++;
    if ({mem_addr, mem_wdata, mem_be} !== 68'h0) begin
      n_fail++;
      $display("FAIL reset_fields: addr=%h wdata=%h be=%b, required all zero", mem_addr, mem_wdata, mem_be);
    end
  endtask
  task automatic test_done(input string name, input logic [2:0] f3, input logic [31:0] a,
                           input logic [31:0] d, input int stall, input bit poke, input int nwr);
    int kind, lat; bit rs, rdy;
    run_store(f3, a, d, stall, poke, kind, lat, rs, rdy);
    n_checks++;
    if (kind !== 1 || lat !== stall + nwr) begin
      n_fail++;
      $display("FAIL %s outcome: kind=%0d lat=%0d, required kind=1 lat=%0d", name, kind, lat, stall + nwr);
    end
    n_checks++;
    if (rdy !== 1'b1 || exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL %s completion: ready=%b pending=%0d, required ready=1 pending=0", name, rdy, exp_q.size());
    end
  endtask
  task automatic test_reject(input string name, input logic [2:0] f3, input logic [31:0] a,
                             input logic [31:0] d, input int want);
    int kind, lat; bit rs, rdy;
    run_store(f3, a, d, 0, 1'b0, kind, lat, rs, rdy);
    n_checks++;
    if (kind !== want || lat !== 0 || rs !== 1'b0 || rdy !== 1'b1) begin
      n_fail++;
      $display("FAIL %s reject: kind=%0d lat=%0d req=%b ready=%b, required kind=%0d lat=0 req=0 ready=1",
               name, kind, lat, rs, rdy, want);
    end
  endtask
  task automatic test_sb();
    push(32'h100, 4'b1000, 32'hDD00_0000);
    test_done("sb_off3", 3'b000, 32'h103, 32'hAABB_CCDD, 0, 0, 1);
    push(32'h200, 4'b0001, 32'h0000_00DD);
    test_done("sb_off0", 3'b000, 32'h200, 32'hAABB_CCDD, 0, 0, 1);
  endtask
  task automatic test_sh_stall();
    push(32'h200, 4'b1100, 32'h1234_0000);
    test_done("sh_stall", 3'b001, 32'h202, 32'hFFFF_1234, 3, 0, 1);
  endtask
  task automatic test_sw_aligned();
    push(32'h104, 4'b1111, 32'h1122_3344);
    test_done("sw_aligned", 3'b010, 32'h104, 32'h1122_3344, 0, 0, 1);
  endtask
  task automatic test_misaligned();
`ifdef MISALIGN_SPLIT_EN
    push(32'h104, 4'b1110, 32'h2233_4400);
    push(32'h108, 4'b0001, 32'h0000_0011);
    test_done("sw_split", 3'b010, 32'h105, 32'h1122_3344, 0, 0, 2);
    push(32'h200, 4'b0110, 32'h0012_3400);
    test_done("sh_off1", 3'b001, 32'h201, 32'h0000_1234, 0, 0, 1);
    push(32'hFFFF_FFFC, 4'b1100, 32'h3344_0000);
    push(32'h0000_0000, 4'b0011, 32'h0000_1122);
    test_done("sw_wrap", 3'b010, 32'hFFFF_FFFE, 32'h1122_3344, 2, 1, 2);
`else
    test_reject("sw_off1", 3'b010, 32'h105, 32'h1122_3344, 2);
    test_reject("sh_off1", 3'b001, 32'h201, 32'h0000_1234, 2);
    test_reject("sw_wrap", 3'b010, 32'hFFFF_FFFE, 32'h1122_3344, 2);
`endif
  endtask
  task automatic test_illegal();
    test_reject("f3_011", 3'b011, 32'h100, 32'h1, 3);
    test_reject("f3_100", 3'b100, 32'h100, 32'h1, 3);
  endtask
  task automatic test_ignore_busy();
    push(32'h300, 4'b1111, 32'hCAFE_F00D);
    test_done("busy_valid", 3'b010, 32'h300, 32'hCAFE_F00D, 3, 1, 1);
  endtask
  task automatic test_back_to_back();
    push(32'h400, 4'b0010, 32'h0000_5A00);
    test_done("b2b_a", 3'b000, 32'h401, 32'h0000_005A, 0, 0, 1);
    push(32'h404, 4'b0011, 32'h0000_BEEF);
    test_done("b2b_b", 3'b001, 32'h404, 32'h0000_BEEF, 0, 0, 1);
  endtask
  task automatic test_reset_mid();
    bit seen = 0;
    @(posedge clk); #1;
`ifdef MISALIGN_SPLIT_EN
    push(32'h104, 4'b1110, 32'h2233_4400);
    push(32'h108, 4'b0001, 32'h0000_0011);
    st_valid = 1'b1; st_funct3 = 3'b010; st_addr = 32'h105; st_data = 32'h1122_3344;
    @(posedge clk); #1;
    st_valid = 1'b0; mem_ready = 1'b1;
    @(posedge clk); #1;
    mem_ready = 1'b0;
`else
    push(32'h500, 4'b1111, 32'h0BAD_F00D);
    st_valid = 1'b1; st_funct3 = 3'b010; st_addr = 32'h500; st_data = 32'h0BAD_F00D;
    @(posedge clk); #1;
    st_valid = 1'b0; mem_ready = 1'b0;
`endif
    @(posedge clk); #1;
    n_checks++;
    if (mem_req !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_mid_busy: mem_req=%b, required 1", mem_req);
    end
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (mem_req !== 1'b0 || st_ready !== 1'b1 || mem_be !== 4'b0) begin
      n_fail++;
      $display("FAIL reset_mid_async: req=%b ready=%b be=%b, required req=0 ready=1 be=0000", mem_req, st_ready, mem_be);
    end
    exp_q.delete();
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      if (st_done) seen = 1;
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      if (st_done || mem_req) seen = 1;
    end
    n_checks++;
    if (seen !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid_done: done_or_req=%b, required 0", seen);
    end
    push(32'h600, 4'b0100, 32'h0077_0000);
    test_done("after_reset", 3'b000, 32'h602, 32'h0000_0077, 0, 0, 1);
  endtask
  initial begin
    rst_n = 1'b0; st_valid = 1'b0; st_funct3 = 3'b0; st_addr = '0; st_data = '0; mem_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    test_reset();
    rst_n = 1'b1;
    test_sb();
    test_sh_stall();
    test_sw_aligned();
    test_misaligned();
    test_illegal();
    test_ignore_busy();
    test_back_to_back();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
